// File: rtl/if_id_fetch_stage.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// if_id_fetch_stage
//
// Glue between the IF stage (PC register + next-PC mux) and decode. Issues
// instruction-memory reads at the current PC, waits for the response, and
// latches {pc, instr, valid} into the IF/ID pipeline register. load_pc tells
// IF when to advance. One fetched instruction can be parked in a skid slot
// while decode stalls. A flush squashes buffered or in-flight fetches.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   pc_in              current PC from IF
//   load_pc            advance/load the IF PC register this cycle
//   imem_read          read request, held until imem_resp
//   imem_address       read address, frozen while a request is outstanding
//   imem_resp          one-cycle response strobe
//   imem_rdata         fetched instruction, valid with imem_resp
//   stall              decode cannot take the IF/ID contents this cycle
//   flush              redirect; IF loads a new target this cycle
//   id_valid           IF/ID register holds a live instruction
//   id_pc, id_instr    IF/ID register contents
// ---------------------------------------------------------------------------
module if_id_fetch_stage #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h00000013)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_in,
    output logic            load_pc,
    output logic            imem_read,
    output logic [XLEN-1:0] imem_address,
    input  logic            imem_resp,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            stall,
    input  logic            flush,
    output logic            id_valid,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_instr
);

    typedef enum logic [1:0] {
        FETCH,
        HOLD,
        SQUASH
    } state_t;

    state_t          state_q, state_d;
    logic            id_valid_q, id_valid_d;
    logic [XLEN-1:0] id_pc_q, id_pc_d;
    logic [XLEN-1:0] id_instr_q, id_instr_d;
    logic [XLEN-1:0] skid_pc_q, skid_pc_d;
    logic [XLEN-1:0] skid_instr_q, skid_instr_d;
    logic [XLEN-1:0] req_addr_q, req_addr_d;
    logic            imem_read_c;
    logic            load_pc_c;
    logic            accept;

    // The IF/ID register can take new data when it is empty or decode is
    // consuming its current contents this cycle.
    assign accept = ~id_valid_q | ~stall;

    // Next-state and request logic. Flush always wins over stall and over
    // any capture, so a flush cycle never writes valid data into IF/ID.
    always_comb begin
        state_d      = state_q;
        id_valid_d   = id_valid_q;
        id_pc_d      = id_pc_q;
        id_instr_d   = id_instr_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;
        req_addr_d   = req_addr_q;
        imem_read_c  = 1'b0;
        load_pc_c    = 1'b0;
        imem_address = req_addr_q;

        case (state_q)
            FETCH: begin
                imem_read_c  = 1'b1;
                imem_address = pc_in;
                req_addr_d   = pc_in;
                if (imem_resp) begin
                    load_pc_c = 1'b1;
                    if (flush) begin
                        id_valid_d = 1'b0;
                        id_instr_d = NOP_INSTR;
                    end else if (accept) begin
                        id_valid_d = 1'b1;
                        id_pc_d    = pc_in;
                        id_instr_d = imem_rdata;
                    end else begin
                        skid_pc_d    = pc_in;
                        skid_instr_d = imem_rdata;
                        state_d      = HOLD;
                    end
                end else if (flush) begin
                    // The request already went out at the old PC; its
                    // response must be swallowed before fetching the target.
                    load_pc_c  = 1'b1;
                    id_valid_d = 1'b0;
                    id_instr_d = NOP_INSTR;
                    state_d    = SQUASH;
                end else if (id_valid_q && !stall) begin
                    id_valid_d = 1'b0;
                end
            end

            HOLD: begin
                load_pc_c = flush;
                if (flush) begin
                    id_valid_d = 1'b0;
                    id_instr_d = NOP_INSTR;
                    state_d    = FETCH;
                end else if (!stall) begin
                    id_valid_d = 1'b1;
                    id_pc_d    = skid_pc_q;
                    id_instr_d = skid_instr_q;
                    state_d    = FETCH;
                end
            end

            SQUASH: begin
                imem_read_c  = 1'b1;
                imem_address = req_addr_q;
                load_pc_c    = flush;
                id_valid_d   = 1'b0;
                if (flush) begin
                    id_instr_d = NOP_INSTR;
                end
                if (imem_resp) begin
                    state_d = FETCH;
                end
            end

            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // Pipeline register, skid slot and request-address flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= FETCH;
            id_valid_q   <= 1'b0;
            id_pc_q      <= '0;
            id_instr_q   <= NOP_INSTR;
            skid_pc_q    <= '0;
            skid_instr_q <= '0;
            req_addr_q   <= '0;
        end else begin
            state_q      <= state_d;
            id_valid_q   <= id_valid_d;
            id_pc_q      <= id_pc_d;
            id_instr_q   <= id_instr_d;
            skid_pc_q    <= skid_pc_d;
            skid_instr_q <= skid_instr_d;
            req_addr_q   <= req_addr_d;
        end
    end

    // Requests and PC loads are suppressed for as long as reset is asserted.
    assign imem_read = imem_read_c & ~rst;
    assign load_pc   = load_pc_c & ~rst;
    assign id_valid  = id_valid_q;
    assign id_pc     = id_pc_q;
    assign id_instr  = id_instr_q;

endmodule

// File: doc/if_id_fetch_stage.md
Name: if_id_fetch_stage

Overview:
- Sits between the IF stage (PC register plus next-PC mux) and decode.
- Issues instruction-memory reads at the current PC and waits for the response.
- Latches {pc, instruction, valid} into the IF/ID pipeline register and generates load_pc back to IF.
- Absorbs one fetched instruction in a skid slot while decode stalls, and squashes in-flight or buffered fetches on a control-flow flush.

Parameters:
- XLEN, 32, width of PC, address and instruction.
- NOP_INSTR, 32'h00000013, value of id_instr at reset and after a flush (addi x0,x0,0).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- pc_in  in  XLEN  current PC from the IF stage.
- load_pc  out  1  advance/load the IF PC register this cycle.
- imem_read  out  1  read request; held high until imem_resp.
- imem_address  out  XLEN  read address; stable while a request is outstanding.
- imem_resp  in  1  one-cycle response strobe; imem_rdata is valid when it is high.
- imem_rdata  in  XLEN  fetched instruction.
- stall  in  1  decode cannot accept the IF/ID contents this cycle.
- flush  in  1  redirect; IF loads a new target this cycle.
- id_valid  out  1  IF/ID register holds a live instruction.
- id_pc  out  XLEN  PC of id_instr.
- id_instr  out  XLEN  instruction to decode.

Behaviour:
- Reset (async, immediate):
  - state=FETCH; id_valid=0; id_pc=0; id_instr=NOP_INSTR; skid empty; req_addr_q=0.
  - imem_read and load_pc are forced to 0 while rst is high.
- accept = ~id_valid | ~stall. This is the IF/ID register's ability to take new data this cycle.
- States: FETCH, HOLD, SQUASH.
- FETCH:
  - imem_read=1; imem_address=pc_in; req_addr_q<=pc_in each cycle.
  - resp & flush: discard data, load_pc=1, id_valid<=0, id_instr<=NOP_INSTR, stay in FETCH.
  - resp & ~flush & accept: id_pc<=pc_in, id_instr<=imem_rdata, id_valid<=1, load_pc=1, stay in FETCH.
  - resp & ~flush & ~accept: skid<={pc_in, imem_rdata}, load_pc=1, go to HOLD. id regs unchanged.
  - ~resp & flush: request is outstanding at the stale address. load_pc=1, id_valid<=0, go to SQUASH.
  - ~resp & ~flush: load_pc=0. If id_valid & ~stall, then id_valid<=0 (bubble).
- HOLD:
  - imem_read=0; load_pc=flush.
  - flush: drop skid, id_valid<=0, go to FETCH.
  - ~stall: id<=skid, id_valid<=1, go to FETCH.
  - stall: hold everything.
- SQUASH:
  - imem_read=1; imem_address=req_addr_q (frozen).
  - load_pc=flush; a flush here keeps SQUASH.
  - id_valid<=0.
  - On resp: discard data, go to FETCH. The next cycle issues at the new pc_in.
- Flush priority: flush overrides stall and any capture. The IF/ID register is never written with valid data in a flush cycle.
- Latency and throughput:
  - imem_resp in cycle N produces id_valid/id_instr in cycle N+1.
  - With a zero-wait memory (resp in the request cycle), throughput is 1 instruction/cycle.
- Ordering and completeness: no instruction is dropped or duplicated without a flush; id_pc sequence equals the sequence of accepted pc_in values.
- At most one request is outstanding; imem_address never changes while imem_read=1 and resp=0.

Test Plan:
- Reset mid-request: rst pulses while imem_read=1 at PC 0x60 -> same cycle id_valid=0, id_instr=0x00000013, imem_read=0; after release, a read at pc_in.
- Zero-wait stream: pc 0x00,0x04,0x08 with resp each cycle, stall=0 -> id_pc 0x00,0x04,0x08 on consecutive cycles, load_pc high every cycle.
- Stall with skid: resp for 0x10 arrives while id holds 0x0C and stall=1 -> HOLD, imem_read=0. Stall drops 3 cycles later -> id_pc=0x10 next cycle, then fetch resumes at 0x14.
- Flush with outstanding miss: request at 0x20 with resp delayed 4 cycles, flush in cycle 1 with IF loading 0x80 -> imem_address stays 0x20 until resp, data discarded, id_valid=0, next request at 0x80.
- Flush in the resp cycle: resp=1 with rdata 0xDEADBEEF and flush=1 -> id_valid=0, id_instr=0x00000013, load_pc=1, next read at the new target.
- Flush in HOLD: skid holds 0x30 and stall=1, flush=1 -> skid dropped, id_valid=0 next cycle, FETCH at the target; 0x30 never appears on id_pc.
